// File: rtl/csr_cpuif_arbiter.sv
// Round-robin arbiter sharing one CSR cpuif port between two upstream requesters.
// Optional watchdog with a DRAIN state is enabled by defining I3C_CSR_ARB_TIMEOUT_EN.
module csr_cpuif_arbiter #(
    parameter int unsigned CsrAddrWidth  = 12,
    parameter int unsigned CsrDataWidth  = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [1:0]                req_i,
    input  logic [1:0]                req_is_wr_i,
    input  logic [2*CsrAddrWidth-1:0] req_addr_i,
    input  logic [2*CsrDataWidth-1:0] req_wr_data_i,
    input  logic [2*CsrDataWidth-1:0] req_wr_biten_i,
    output logic [1:0]                req_stall_o,
    output logic [1:0]                req_ack_o,
    output logic [1:0]                req_err_o,
    output logic [CsrDataWidth-1:0]   req_rd_data_o,
    output logic                      s_cpuif_req,
    output logic                      s_cpuif_req_is_wr,
    output logic [CsrAddrWidth-1:0]   s_cpuif_addr,
    output logic [CsrDataWidth-1:0]   s_cpuif_wr_data,
    output logic [CsrDataWidth-1:0]   s_cpuif_wr_biten,
    input  logic                      s_cpuif_req_stall_wr,
    input  logic                      s_cpuif_req_stall_rd,
    input  logic                      s_cpuif_rd_ack,
    input  logic                      s_cpuif_rd_err,
    input  logic                      s_cpuif_wr_ack,
    input  logic                      s_cpuif_wr_err,
    input  logic [CsrDataWidth-1:0]   s_cpuif_rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
`ifdef I3C_CSR_ARB_TIMEOUT_EN
        , ST_DRAIN = 2'd3
`endif
    } state_e;

    state_e                  state_q, state_d;
    logic                    grant_q, grant_d;
    logic                    prio_q, prio_d;
    logic                    is_wr_q, is_wr_d;
    logic [CsrAddrWidth-1:0] addr_q, addr_d;
    logic [CsrDataWidth-1:0] wr_data_q, wr_data_d;
    logic [CsrDataWidth-1:0] wr_biten_q, wr_biten_d;

    logic       win_idx;
    logic       accept_en;
    logic [1:0] accept;
    logic       ds_stall;
    logic       ds_ack;
    logic       ds_err;
    logic       done;
    logic       timeout;

    // A lone requester wins; a tie goes to prio. Nothing is accepted while in reset.
    always_comb begin
        win_idx   = (req_i == 2'b11) ? prio_q : req_i[1];
        accept_en = rst_ni && (state_q == ST_IDLE) && (|req_i);
        accept    = accept_en ? (2'b01 << win_idx) : 2'b00;
        ds_stall  = is_wr_q ? s_cpuif_req_stall_wr : s_cpuif_req_stall_rd;
        ds_ack    = s_cpuif_rd_ack | s_cpuif_wr_ack;
        ds_err    = (s_cpuif_rd_ack & s_cpuif_rd_err) | (s_cpuif_wr_ack & s_cpuif_wr_err);
        done      = ((state_q == ST_ISSUE) && !ds_stall && ds_ack) ||
                    ((state_q == ST_WAIT) && ds_ack);
    end

`ifdef I3C_CSR_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    // A real ack in the same cycle takes precedence over the watchdog.
    assign timeout = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && !done &&
                     (cnt_q == 8'(TimeoutCycles));
`else
    logic unused_timeout_cfg;

    assign timeout            = 1'b0;
    assign unused_timeout_cfg = ^32'(TimeoutCycles);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            prio_q     <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            wr_biten_q <= '0;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
            cnt_q      <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            prio_q     <= prio_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            wr_biten_q <= wr_biten_d;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        prio_d     = prio_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wr_data_d  = wr_data_q;
        wr_biten_d = wr_biten_q;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (accept_en) begin
                    grant_d    = win_idx;
                    is_wr_d    = req_is_wr_i[win_idx];
                    addr_d     = win_idx ? req_addr_i[2*CsrAddrWidth-1:CsrAddrWidth]
                                         : req_addr_i[CsrAddrWidth-1:0];
                    wr_data_d  = win_idx ? req_wr_data_i[2*CsrDataWidth-1:CsrDataWidth]
                                         : req_wr_data_i[CsrDataWidth-1:0];
                    wr_biten_d = win_idx ? req_wr_biten_i[2*CsrDataWidth-1:CsrDataWidth]
                                         : req_wr_biten_i[CsrDataWidth-1:0];
                    state_d    = ST_ISSUE;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end
            end
            ST_ISSUE: if (!ds_stall) state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_WAIT;
`ifdef I3C_CSR_ARB_TIMEOUT_EN
            // Swallow the late ack of an abandoned access.
            ST_DRAIN: if (ds_ack) state_d = ST_IDLE;
`endif
            default:  state_d = ST_IDLE;
        endcase
        if (done) begin
            state_d = ST_IDLE;
            prio_d  = ~grant_q;
        end
`ifdef I3C_CSR_ARB_TIMEOUT_EN
        if ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) cnt_d = cnt_q + 8'd1;
        if (timeout) begin
            prio_d  = ~grant_q;
            state_d = (state_q == ST_WAIT) ? ST_DRAIN : ST_IDLE;
        end
`endif
    end

    always_comb begin
        req_stall_o       = req_i & ~accept;
        req_ack_o         = 2'b00;
        req_err_o         = 2'b00;
        req_rd_data_o     = '0;
        s_cpuif_req       = (state_q == ST_ISSUE) && !timeout;
        s_cpuif_req_is_wr = 1'b0;
        s_cpuif_addr      = '0;
        s_cpuif_wr_data   = '0;
        s_cpuif_wr_biten  = '0;
        if (s_cpuif_req) begin
            s_cpuif_req_is_wr = is_wr_q;
            s_cpuif_addr      = addr_q;
            s_cpuif_wr_data   = wr_data_q;
            s_cpuif_wr_biten  = wr_biten_q;
        end
        if (done) begin
            req_ack_o[grant_q] = 1'b1;
            req_err_o[grant_q] = ds_err;
            if (s_cpuif_rd_ack) req_rd_data_o = s_cpuif_rd_data;
        end
        if (timeout) begin
            req_ack_o[grant_q] = 1'b1;
            req_err_o[grant_q] = 1'b1;
        end
    end

endmodule

// File: tb/tb_csr_cpuif_arbiter.sv
// Self-checking bench for csr_cpuif_arbiter: directed vector table, watchdog sequence
// (when I3C_CSR_ARB_TIMEOUT_EN is defined) and a randomized run against a transaction model.
module tb_csr_cpuif_arbiter;
    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    localparam logic [DW-1:0] WD0 = 32'hA0A0_0001;
    localparam logic [DW-1:0] WD1 = 32'hB1B1_0002;
    localparam logic [DW-1:0] BE0 = 32'hFFFF_FFFF;
    localparam logic [DW-1:0] BE1 = 32'h0000_FFFF;

    // downstream input bundle: {stall_wr, stall_rd, rd_ack, rd_err, wr_ack, wr_err}
    localparam logic [5:0] D_SW = 6'b100000;
    localparam logic [5:0] D_SR = 6'b010000;
    localparam logic [5:0] D_RA = 6'b001000;
    localparam logic [5:0] D_RE = 6'b000100;
    localparam logic [5:0] D_WA = 6'b000010;
    localparam logic [5:0] D_WE = 6'b000001;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic [1:0]      req_i, req_is_wr_i;
    logic [2*AW-1:0] req_addr_i;
    logic [2*DW-1:0] req_wr_data_i, req_wr_biten_i;
    logic [1:0]      req_stall_o, req_ack_o, req_err_o;
    logic [DW-1:0]   req_rd_data_o;
    logic            s_cpuif_req, s_cpuif_req_is_wr;
    logic [AW-1:0]   s_cpuif_addr;
    logic [DW-1:0]   s_cpuif_wr_data, s_cpuif_wr_biten;
    logic            s_cpuif_req_stall_wr, s_cpuif_req_stall_rd;
    logic            s_cpuif_rd_ack, s_cpuif_rd_err, s_cpuif_wr_ack, s_cpuif_wr_err;
    logic [DW-1:0]   s_cpuif_rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    csr_cpuif_arbiter #(
        .CsrAddrWidth (AW),
        .CsrDataWidth (DW),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .req_i               (req_i),
        .req_is_wr_i         (req_is_wr_i),
        .req_addr_i          (req_addr_i),
        .req_wr_data_i       (req_wr_data_i),
        .req_wr_biten_i      (req_wr_biten_i),
        .req_stall_o         (req_stall_o),
        .req_ack_o           (req_ack_o),
        .req_err_o           (req_err_o),
        .req_rd_data_o       (req_rd_data_o),
        .s_cpuif_req         (s_cpuif_req),
        .s_cpuif_req_is_wr   (s_cpuif_req_is_wr),
        .s_cpuif_addr        (s_cpuif_addr),
        .s_cpuif_wr_data     (s_cpuif_wr_data),
        .s_cpuif_wr_biten    (s_cpuif_wr_biten),
        .s_cpuif_req_stall_wr(s_cpuif_req_stall_wr),
        .s_cpuif_req_stall_rd(s_cpuif_req_stall_rd),
        .s_cpuif_rd_ack      (s_cpuif_rd_ack),
        .s_cpuif_rd_err      (s_cpuif_rd_err),
        .s_cpuif_wr_ack      (s_cpuif_wr_ack),
        .s_cpuif_wr_err      (s_cpuif_wr_err),
        .s_cpuif_rd_data     (s_cpuif_rd_data)
    );

    typedef struct {
        logic          rst_n;
        logic [1:0]    req;
        logic [1:0]    wr;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [5:0]    dn;
        logic [DW-1:0] rdata;
        logic [1:0]    e_stall;
        logic [1:0]    e_ack;
        logic [1:0]    e_err;
        logic [DW-1:0] e_rdata;
        logic          e_sreq;
        logic          e_swr;
        logic [AW-1:0] e_saddr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, input logic [1:0] req, input logic [1:0] wr,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [5:0] dn, input logic [DW-1:0] rdata,
                                input logic [1:0] e_stall, input logic [1:0] e_ack,
                                input logic [1:0] e_err, input logic [DW-1:0] e_rdata,
                                input logic e_sreq, input logic e_swr, input logic [AW-1:0] e_saddr);
        vec_t v;
        v.rst_n = rst_n; v.req = req; v.wr = wr; v.a0 = a0; v.a1 = a1; v.dn = dn;
        v.rdata = rdata; v.e_stall = e_stall; v.e_ack = e_ack; v.e_err = e_err;
        v.e_rdata = e_rdata; v.e_sreq = e_sreq; v.e_swr = e_swr; v.e_saddr = e_saddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_dn(input logic [5:0] dn);
        {s_cpuif_req_stall_wr, s_cpuif_req_stall_rd, s_cpuif_rd_ack,
         s_cpuif_rd_err, s_cpuif_wr_ack, s_cpuif_wr_err} = dn;
    endtask

    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_ni = 1'b0; req_i = 2'b00; req_is_wr_i = 2'b00; set_dn(6'b0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
    endtask

    // Random-run model state
    logic          m_prio, m_own, m_wr, w, stall_now, ack_now, e_err_bit;
    logic [1:0]    pend, awaiting, acc;
    int            m_phase;
    int unsigned   stall_left, delay_left;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_be;
    logic [1:0]    r_wr;
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wd[2];
    logic [DW-1:0] r_be[2];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b1; req_i = 2'b11; req_is_wr_i = 2'b01;
        req_addr_i = {12'h0AB, 12'h0CD}; req_wr_data_i = {WD1, WD0}; req_wr_biten_i = {BE1, BE0};
        set_dn(D_RA | D_WA); s_cpuif_rd_data = 32'h1357_9BDF;
        #2 rst_ni = 1'b0;
        #2;
        chk("reset_stall",  64'(req_stall_o), 64'(2'b11));
        chk("reset_ack",    64'(req_ack_o), 64'd0);
        chk("reset_err",    64'(req_err_o), 64'd0);
        chk("reset_rdata",  64'(req_rd_data_o), 64'd0);
        chk("reset_sreq",   64'({s_cpuif_req, s_cpuif_req_is_wr}), 64'd0);
        chk("reset_saddr",  64'(s_cpuif_addr), 64'd0);
        chk("reset_swdata", 64'({s_cpuif_wr_data, s_cpuif_wr_biten}), 64'd0);

        //                rst req    wr     a0      a1      dn           rdata          stall  ack    err    e_rdata        sreq  swr   saddr
        vecs.push_back(mk(1, 2'b01, 2'b00, 12'h010, 12'h000, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b00, 2'b00, 12'h010, 12'h000, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b1, 1'b0, 12'h010));
        vecs.push_back(mk(1, 2'b00, 2'b00, 12'h010, 12'h000, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b00, 2'b00, 12'h010, 12'h000, D_RA,        32'hDEADBEEF,  2'b00, 2'b01, 2'b00, 32'hDEADBEEF,  1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(0, 2'b11, 2'b01, 12'h020, 12'h030, 6'b0,        32'h0,         2'b11, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b11, 2'b01, 12'h020, 12'h030, 6'b0,        32'h0,         2'b10, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b10, 2'b01, 12'h020, 12'h030, D_WA,        32'h55555555,  2'b10, 2'b01, 2'b00, 32'h0,         1'b1, 1'b1, 12'h020));
        vecs.push_back(mk(1, 2'b10, 2'b01, 12'h020, 12'h030, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b00, 2'b00, 12'h020, 12'h030, D_RA,        32'h12345678,  2'b00, 2'b10, 2'b00, 32'h12345678,  1'b1, 1'b0, 12'h030));
        vecs.push_back(mk(1, 2'b11, 2'b00, 12'h024, 12'h034, 6'b0,        32'h0,         2'b10, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b10, 2'b00, 12'h024, 12'h034, D_RA | D_RE, 32'hCAFE0000,  2'b10, 2'b01, 2'b01, 32'hCAFE0000,  1'b1, 1'b0, 12'h024));
        vecs.push_back(mk(1, 2'b10, 2'b10, 12'h024, 12'h044, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b00, 2'b10, 12'h050, 12'h044, D_SW,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b1, 1'b1, 12'h044));
        vecs.push_back(mk(1, 2'b01, 2'b10, 12'h050, 12'h044, D_SW,        32'h0,         2'b01, 2'b00, 2'b00, 32'h0,         1'b1, 1'b1, 12'h044));
        vecs.push_back(mk(1, 2'b01, 2'b10, 12'h050, 12'h044, D_SW,        32'h0,         2'b01, 2'b00, 2'b00, 32'h0,         1'b1, 1'b1, 12'h044));
        vecs.push_back(mk(1, 2'b01, 2'b10, 12'h050, 12'h044, D_SR,        32'h0,         2'b01, 2'b00, 2'b00, 32'h0,         1'b1, 1'b1, 12'h044));
        vecs.push_back(mk(1, 2'b01, 2'b10, 12'h050, 12'h044, D_WA | D_WE, 32'hFFFFFFFF,  2'b01, 2'b10, 2'b10, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b01, 2'b00, 12'h050, 12'h044, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b00, 2'b00, 12'h050, 12'h044, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b1, 1'b0, 12'h050));
        vecs.push_back(mk(1, 2'b00, 2'b00, 12'h050, 12'h044, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(0, 2'b10, 2'b00, 12'h050, 12'h060, D_RA,        32'h77777777,  2'b10, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b00, 2'b00, 12'h050, 12'h060, D_RA,        32'h77777777,  2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b10, 2'b00, 12'h050, 12'h060, 6'b0,        32'h0,         2'b00, 2'b00, 2'b00, 32'h0,         1'b0, 1'b0, 12'h000));
        vecs.push_back(mk(1, 2'b00, 2'b00, 12'h050, 12'h060, D_RA,        32'h0BADF00D,  2'b00, 2'b10, 2'b00, 32'h0BADF00D,  1'b1, 1'b0, 12'h060));

        foreach (vecs[i]) begin
            @(posedge clk_i); #1;
            rst_ni = vecs[i].rst_n; req_i = vecs[i].req; req_is_wr_i = vecs[i].wr;
            req_addr_i = {vecs[i].a1, vecs[i].a0}; req_wr_data_i = {WD1, WD0};
            req_wr_biten_i = {BE1, BE0}; set_dn(vecs[i].dn); s_cpuif_rd_data = vecs[i].rdata;
            @(negedge clk_i);
            chk($sformatf("vec%0d_stall", i), 64'(req_stall_o), 64'(vecs[i].e_stall));
            chk($sformatf("vec%0d_ack", i),   64'(req_ack_o),   64'(vecs[i].e_ack));
            chk($sformatf("vec%0d_err", i),   64'(req_err_o),   64'(vecs[i].e_err));
            chk($sformatf("vec%0d_rdata", i), 64'(req_rd_data_o), 64'(vecs[i].e_rdata));
            chk($sformatf("vec%0d_sreq", i),  64'(s_cpuif_req), 64'(vecs[i].e_sreq));
            if (vecs[i].e_sreq) begin
                chk($sformatf("vec%0d_swr", i),   64'(s_cpuif_req_is_wr), 64'(vecs[i].e_swr));
                chk($sformatf("vec%0d_saddr", i), 64'(s_cpuif_addr), 64'(vecs[i].e_saddr));
            end
        end

`ifdef I3C_CSR_ARB_TIMEOUT_EN
        // Read that is never acked: error ack TO+1 cycles after accept, late ack swallowed.
        do_reset();
        @(posedge clk_i); #1;
        req_i = 2'b01; req_is_wr_i = 2'b00; set_dn(6'b0); s_cpuif_rd_data = 32'h0000_00AA;
        @(negedge clk_i);
        chk("to_accept", 64'(req_stall_o), 64'd0);
        for (int c = 1; c <= int'(TO); c++) begin
            @(posedge clk_i); #1;
            req_i = 2'b00;
            @(negedge clk_i);
            chk($sformatf("to_wait%0d_ack", c), 64'(req_ack_o), 64'd0);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("to_ack",   64'(req_ack_o), 64'(2'b01));
        chk("to_err",   64'(req_err_o), 64'(2'b01));
        chk("to_rdata", 64'(req_rd_data_o), 64'd0);
        @(posedge clk_i); #1;
        req_i = 2'b10; set_dn(D_RA);
        @(negedge clk_i);
        chk("drain_stall", 64'(req_stall_o), 64'(2'b10));
        chk("drain_ack",   64'(req_ack_o), 64'd0);
        @(posedge clk_i); #1;
        set_dn(6'b0);
        @(negedge clk_i);
        chk("post_drain_accept", 64'(req_stall_o), 64'd0);
`endif

        // Randomized run against a transaction-level model.
        do_reset();
        m_prio = 1'b0; m_own = 1'b0; m_wr = 1'b0; m_phase = 0; pend = 2'b00; awaiting = 2'b00;
        stall_left = 0; delay_left = 0; m_addr = '0; m_wd = '0; m_be = '0; r_wr = 2'b00;
        for (int n = 0; n < 2; n++) begin r_addr[n] = '0; r_wd[n] = '0; r_be[n] = '0; end
        for (int c = 0; c < 400; c++) begin
            @(posedge clk_i); #1;
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && !awaiting[n] && ($urandom_range(0, 2) == 0)) begin
                    pend[n]   = 1'b1;
                    r_wr[n]   = 1'($urandom);
                    r_addr[n] = AW'($urandom);
                    r_wd[n]   = $urandom;
                    r_be[n]   = $urandom;
                end
            end
            req_i = pend; req_is_wr_i = r_wr;
            req_addr_i = {r_addr[1], r_addr[0]};
            req_wr_data_i = {r_wd[1], r_wd[0]};
            req_wr_biten_i = {r_be[1], r_be[0]};

            stall_now = (m_phase == 1) && (stall_left > 0);
            ack_now   = ((m_phase == 1) && !stall_now && (delay_left == 0)) ||
                        ((m_phase == 2) && (delay_left == 0));
            s_cpuif_req_stall_wr = (m_phase == 1 && m_wr) ? stall_now : 1'($urandom);
            s_cpuif_req_stall_rd = (m_phase == 1 && !m_wr) ? stall_now : 1'($urandom);
            s_cpuif_rd_ack  = ack_now && !m_wr;
            s_cpuif_wr_ack  = ack_now && m_wr;
            s_cpuif_rd_err  = 1'($urandom);
            s_cpuif_wr_err  = 1'($urandom);
            s_cpuif_rd_data = $urandom;

            w   = (pend == 2'b11) ? m_prio : pend[1];
            acc = (m_phase == 0 && pend != 2'b00) ? (2'b01 << w) : 2'b00;
            e_err_bit = m_wr ? s_cpuif_wr_err : s_cpuif_rd_err;

            @(negedge clk_i);
            chk($sformatf("rnd%0d_stall", c), 64'(req_stall_o), 64'(pend & ~acc));
            chk($sformatf("rnd%0d_ack", c), 64'(req_ack_o),
                64'(ack_now ? (2'b01 << m_own) : 2'b00));
            chk($sformatf("rnd%0d_err", c), 64'(req_err_o),
                64'((ack_now && e_err_bit) ? (2'b01 << m_own) : 2'b00));
            chk($sformatf("rnd%0d_rdata", c), 64'(req_rd_data_o),
                64'((ack_now && !m_wr) ? s_cpuif_rd_data : 32'h0));
            chk($sformatf("rnd%0d_sreq", c), 64'(s_cpuif_req), 64'(m_phase == 1));
            if (m_phase == 1) begin
                chk($sformatf("rnd%0d_sfields", c),
                    64'({s_cpuif_req_is_wr, s_cpuif_addr}), 64'({m_wr, m_addr}));
                chk($sformatf("rnd%0d_sdata", c),
                    64'({s_cpuif_wr_data, s_cpuif_wr_biten}), 64'({m_wd, m_be}));
            end

            if (ack_now) begin
                m_phase = 0; m_prio = ~m_own; awaiting[m_own] = 1'b0;
            end else if (m_phase == 1) begin
                if (stall_now) stall_left--;
                else begin m_phase = 2; delay_left--; end
            end else if (m_phase == 2) begin
                delay_left--;
            end else if (acc != 2'b00) begin
                m_own = w; m_wr = r_wr[w]; m_addr = r_addr[w]; m_wd = r_wd[w]; m_be = r_be[w];
                pend[w] = 1'b0; awaiting[w] = 1'b1; m_phase = 1;
                stall_left = $urandom_range(0, 3); delay_left = $urandom_range(0, 3);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_cpuif_arbiter.md
# csr_cpuif_arbiter

Two-requester arbiter that shares the single I3C SW CSR cpuif port between two bus front-ends, e.g. the AXI adapter and an internal or debug requester. Each upstream side sees a cpuif-style port. The arbiter grants one access at a time, round-robin, and holds the grant until the downstream CSR block acknowledges. It also forwards the ack, error and read data back to the granted requester.

## Interface
Parameters:
- CsrAddrWidth, 12, CSR address width.
- CsrDataWidth, 32, CSR data width.
- TimeoutCycles, 255, cycle limit for the watchdog. Used only with I3C_CSR_ARB_TIMEOUT_EN; allowed range 2..255.

Ports (index n in {0,1}; vectors are packed, requester n occupies slice n):
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  2  upstream request.
- req_is_wr_i  in  2  1 = write.
- req_addr_i  in  2*CsrAddrWidth  address.
- req_wr_data_i  in  2*CsrDataWidth  write data.
- req_wr_biten_i  in  2*CsrDataWidth  write bit enables.
- req_stall_o  out  2  request not accepted this cycle.
- req_ack_o  out  2  access complete (read or write).
- req_err_o  out  2  error qualifier, valid with req_ack_o.
- req_rd_data_o  out  CsrDataWidth  read data, shared by both requesters, valid with req_ack_o.
- s_cpuif_req, s_cpuif_req_is_wr  out  1  downstream request and direction.
- s_cpuif_addr  out  CsrAddrWidth  downstream address.
- s_cpuif_wr_data, s_cpuif_wr_biten  out  CsrDataWidth  downstream write data and bit enables.
- s_cpuif_req_stall_wr, s_cpuif_req_stall_rd  in  1  downstream stall, per direction.
- s_cpuif_rd_ack, s_cpuif_rd_err, s_cpuif_wr_ack, s_cpuif_wr_err  in  1  downstream ack and error.
- s_cpuif_rd_data  in  CsrDataWidth  downstream read data.

## Operation
- States: IDLE, ISSUE, WAIT, and DRAIN (DRAIN exists only with the macro).
- Registers:
  - grant: 1 bit, the owner of the current access.
  - prio: 1 bit, the requester that wins a tie; resets to 0.
  - Captured request fields: is_wr, addr, wr_data, wr_biten.
- Upstream handshake:
  - A request is accepted in the cycle where req_i[n]=1 and req_stall_o[n]=0.
  - The requester then drops req_i and waits for req_ack_o[n].
  - req_stall_o = req_i & ~accept, combinationally.
- IDLE:
  - If only one requester asserts req_i, that requester wins.
  - If both assert, requester prio wins.
  - On a win: capture the winner's fields, set grant, go to ISSUE. The loser stays stalled.
- ISSUE:
  - Drive s_cpuif_req=1 with the captured fields.
  - The downstream stall is s_cpuif_req_stall_wr if is_wr, else s_cpuif_req_stall_rd.
  - Stall=1: stay in ISSUE, holding all fields stable.
  - Stall=0 and no ack this cycle: go to WAIT.
  - Stall=0 and an ack in the same cycle: complete immediately.
- WAIT:
  - s_cpuif_req=0.
  - On s_cpuif_rd_ack or s_cpuif_wr_ack: complete.
- Complete:
  - req_ack_o[grant]=1 in the same cycle as the downstream ack.
  - req_err_o[grant] = rd_err or wr_err, matching the ack that fired.
  - req_rd_data_o = s_cpuif_rd_data on a read ack, else 0.
  - prio ← ~grant; go to IDLE.
- Outside an ack cycle, req_ack_o, req_err_o and req_rd_data_o are 0.
- An ack that arrives in IDLE is ignored; it indicates a protocol violation.

## Timing
- Reset values:
  - State IDLE, prio 0, grant 0, captured fields 0.
  - All s_cpuif_* outputs 0; req_ack_o, req_err_o and req_rd_data_o 0.
  - req_stall_o = req_i while in reset.
- Latency:
  - Upstream accept at cycle 0; s_cpuif_req at cycle 1.
  - Downstream ack at cycle k ≥ 1 gives upstream ack at cycle k, combinationally.
- Minimum spacing is 2 cycles per access (accept in IDLE, then a 1-cycle ISSUE with same-cycle ack). The next accept is possible in the cycle after the ack.
- Simultaneous requests in IDLE are served alternately, with no starvation.
- Reset asserted mid-access: the access is abandoned and nothing is forwarded. The requester must also be reset.

## Configuration
- I3C_CSR_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to ISSUE and increments in ISSUE and WAIT.
  - When the count reaches TimeoutCycles, return req_ack_o[grant]=1, req_err_o[grant]=1, req_rd_data_o=0.
  - prio ← ~grant.
  - A timeout in ISSUE drops s_cpuif_req and goes to IDLE.
  - A timeout in WAIT goes to DRAIN. DRAIN stalls all requesters and swallows the next downstream ack, then goes to IDLE.
- Undefined: no counter, no DRAIN state; WAIT waits indefinitely.

## Test plan
- Single read: req0 read addr 0x010 → s_cpuif_req at cycle 1; rd_ack with data 0xDEADBEEF two cycles later → req_ack_o=2'b01 with data 0xDEADBEEF in the same cycle.
- Simultaneous after reset: req0 write and req1 read both in cycle 0 → req0 granted first, req_stall_o[1]=1. After its ack, req1 is issued; then a second tie goes to req0 again (prio=0 after req1 completes).
- Downstream stall: s_cpuif_req_stall_wr=1 for 3 cycles on a write → s_cpuif_req and fields are held for 4 cycles, then WAIT.
- Write error: wr_ack with wr_err=1 → req_ack_o[1]=1 and req_err_o[1]=1, req_rd_data_o=0.
- Reset mid-WAIT: rst_ni low during WAIT → all outputs 0 and state IDLE. A later stray ack is ignored.
- Timeout (macro on, TimeoutCycles=8): no ack → error ack at cycle 9 after the downstream request. A late ack is swallowed in DRAIN, and a new req1 is then accepted.
